// File: rtl/stage_scroll_if.sv
// Control/observation bundle between the game input logic and the scroll sequencer.
// The master side drives frame timing and player/collision events.
interface stage_scroll_if;
    logic        new_frame;
    logic        start;
    logic        hit;
    logic        pause;
    logic [3:0]  speed;
    logic [7:0]  shift;
    logic        running;
    logic        spawn;
    logic [15:0] distance;
    logic [1:0]  state;

    modport master (
        output new_frame, start, hit, pause, speed,
        input  shift, running, spawn, distance, state
    );

    modport slave (
        input  new_frame, start, hit, pause, speed,
        output shift, running, spawn, distance, state
    );
endinterface

// File: rtl/stage_scroll_ctrl.sv
// Game-level run/pause/dead sequencer with per-frame sub-pixel ground scroll,
// run distance counter and pipe-spawn pulse generation.
module stage_scroll_ctrl #(
    parameter int unsigned PERIOD      = 28,
    parameter int unsigned IDLE_STEP   = 4,
    parameter int unsigned SPAWN_DIST  = 96,
    parameter int unsigned DEAD_FRAMES = 60
) (
    input  logic           clk,
    input  logic           rstn,
    stage_scroll_if.slave  bus
);

    localparam int unsigned PIX_W  = $clog2(PERIOD);
    localparam int unsigned SUM_W  = PIX_W + 1;
    localparam int unsigned ACC_W  = $clog2(SPAWN_DIST + 4);
    localparam int unsigned DT_W   = $clog2(DEAD_FRAMES + 1);
    localparam int unsigned DIST_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                running_q, running_d;
    logic                spawn_q, spawn_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [1:0]          frac_q, frac_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DT_W-1:0]     dt_q, dt_d;

    logic [3:0]          step;
    logic [4:0]          frac_sum;
    logic [2:0]          inc;
    logic [SUM_W-1:0]    pix_sum;
    logic [DIST_W:0]     dist_sum;
    logic [ACC_W-1:0]    acc_sum;

    // Frame arithmetic and state transitions; updates use the pre-transition state.
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        frac_d   = frac_q;
        dist_d   = dist_q;
        acc_d    = acc_q;
        dt_d     = dt_q;
        spawn_d  = 1'b0;
        step     = 4'd0;

        case (state_q)
            ST_IDLE: step = 4'(IDLE_STEP);
            ST_RUN:  step = bus.speed;
            default: step = 4'd0;
        endcase

        frac_sum = 5'(frac_q) + 5'(step);
        inc      = frac_sum[4:2];
        pix_sum  = SUM_W'(pix_q) + SUM_W'(inc);
        // A step is always shorter than the period, so a single wrap is enough.
        if (pix_sum >= SUM_W'(PERIOD)) begin
            pix_sum = pix_sum - SUM_W'(PERIOD);
        end
        dist_sum = (DIST_W+1)'(dist_q) + (DIST_W+1)'(inc);
        acc_sum  = acc_q + ACC_W'(inc);

        if (bus.new_frame) begin
            pix_d  = PIX_W'(pix_sum);
            frac_d = frac_sum[1:0];
            if (state_q == ST_RUN) begin
                dist_d = dist_sum[DIST_W] ? {DIST_W{1'b1}} : dist_sum[DIST_W-1:0];
                if (acc_sum >= ACC_W'(SPAWN_DIST)) begin
                    acc_d   = acc_sum - ACC_W'(SPAWN_DIST);
                    spawn_d = 1'b1;
                end else begin
                    acc_d = acc_sum;
                end
            end
            if (state_q == ST_DEAD && dt_q != DT_W'(DEAD_FRAMES)) begin
                dt_d = dt_q + DT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    dist_d  = '0;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.hit) begin
                    state_d = ST_DEAD;
                    dt_d    = '0;
                end else if (bus.pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DEAD: begin
                if (bus.start && dt_q == DT_W'(DEAD_FRAMES)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            spawn_q   <= 1'b0;
            pix_q     <= '0;
            frac_q    <= '0;
            dist_q    <= '0;
            acc_q     <= '0;
            dt_q      <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            spawn_q   <= spawn_d;
            pix_q     <= pix_d;
            frac_q    <= frac_d;
            dist_q    <= dist_d;
            acc_q     <= acc_d;
            dt_q      <= dt_d;
        end
    end

    assign bus.shift    = 8'(pix_q);
    assign bus.running  = running_q;
    assign bus.spawn    = spawn_q;
    assign bus.distance = dist_q;
    assign bus.state    = state_q;

endmodule
